tx_write_arbiter_256: RTL
=========================

Name: tx_write_arbiter_256

Overview:
- Shares the single engine TX write path (request / address / length / 256-bit data / sent) among C_NUM_CHNL channel TX ports.
- Each channel TX port presents write requests; this block grants one at a time, round-robin.
- It forwards the granted request to the engine, steers data read-enables and the sent pulse back to the owner, then rotates priority.
- Exactly one write is outstanding at the engine at any time.

Parameters:
- C_NUM_CHNL, 4, number of channel requesters (1..12).
- C_DATA_WIDTH, 256, data path width in bits (fixed at 256; beat = 8 dwords).
- C_CHNL_W, clog2s(C_NUM_CHNL), width of granted-channel index.

Ports:
- CLK  in  1  core clock; all logic on rising edge.
- RST  in  1  synchronous active-high reset.
- CHNL_TX_REQ  in  C_NUM_CHNL  per-channel write request; held until its ack.
- CHNL_TX_REQ_ACK  out  C_NUM_CHNL  one-cycle per-channel request accepted.
- CHNL_TX_ADDR  in  64*C_NUM_CHNL  per-channel write address; channel i at [64i+63:64i].
- CHNL_TX_LEN  in  10*C_NUM_CHNL  per-channel length in dwords; 0 means 1024.
- CHNL_TX_DATA  in  256*C_NUM_CHNL  per-channel write data.
- CHNL_TX_DATA_REN  out  C_NUM_CHNL  per-channel data read enable.
- CHNL_TX_SENT  out  C_NUM_CHNL  per-channel write complete pulse.
- ENG_TX_REQ  out  1  write request to engine.
- ENG_TX_REQ_ACK  in  1  engine accepted request.
- ENG_TX_ADDR  out  64  latched address of granted channel.
- ENG_TX_LEN  out  10  latched length of granted channel.
- ENG_TX_CHNL  out  C_CHNL_W  granted channel index.
- ENG_TX_DATA  out  256  data of granted channel.
- ENG_TX_DATA_REN  in  1  engine consumes one beat.
- ENG_TX_SENT  in  1  engine finished the write.

Behaviour:
- Reset values: state IDLE; grant one-hot = 0; priority pointer = 0; ENG_TX_REQ = 0; ENG_TX_ADDR/LEN/CHNL = 0. All CHNL_TX_REQ_ACK / DATA_REN / SENT outputs = 0. ENG_TX_DATA = 0 while grant = 0.
- Reset mid-operation: same values next cycle; in-flight write abandoned; no ack or sent pulse issued.
- States:
  - IDLE: if any CHNL_TX_REQ is set, pick the first set bit searching from pointer upward with wrap. Register grant, index, ADDR and LEN of the winner. Next state REQ, with ENG_TX_REQ = 1 the next cycle (1-cycle latency). Otherwise stay in IDLE.
  - REQ: hold ENG_TX_REQ = 1 and stable ADDR/LEN/CHNL until ENG_TX_REQ_ACK. In the ack cycle, CHNL_TX_REQ_ACK[g] = 1, driven combinationally (ENG_TX_REQ_ACK & REQ & grant[g]). Next state XFER and ENG_TX_REQ = 0.
  - XFER: stay until ENG_TX_SENT. In the SENT cycle, CHNL_TX_SENT[g] = 1 (combinational, single cycle). Next state IDLE; pointer = g+1, wrapping to 0 at C_NUM_CHNL; grant cleared.
- Data steering:
  - ENG_TX_DATA = CHNL_TX_DATA of the granted channel (combinational mux) in REQ and XFER; 0 when no grant.
  - CHNL_TX_DATA_REN[g] = ENG_TX_DATA_REN & grant[g]; non-granted channels never see REN.
  - REN accepted in REQ state, same cycle as the ack, or later.
- Protocol faults:
  - ENG_TX_SENT in IDLE is ignored.
  - ENG_TX_SENT in REQ is ignored.
  - A granted channel dropping CHNL_TX_REQ before its ack does not cancel the latched request.
- Simultaneous events:
  - New requests arriving during REQ/XFER wait; arbitration occurs only in IDLE.
  - SENT coinciding with the last REN: both honoured.
- Throughput: SENT at cycle t, IDLE at t+1, next ENG_TX_REQ at t+2.

Optional Feature:
- Macro: TX_ARB_BEAT_CHECK_EN.
- With it:
  - Adds output ERR (1 bit, reset 0, sticky until RST).
  - Expected beats = ceil(LEN/8), with LEN 0 giving 128 beats, in an 8-bit counter loaded at grant.
  - Each REN decrements the counter.
  - ERR sets on REN with counter 0, or on SENT with counter nonzero.
- Without it: no counter, no ERR port; behaviour otherwise identical.

Test Plan:
- Ch1 requests ADDR=0x1000, LEN=16 -> ENG_TX_REQ rises 1 cycle later with ADDR 0x1000, LEN 16, CHNL 1. Ack -> CHNL_TX_REQ_ACK[1] pulses. 2 RENs reach only ch1. SENT -> CHNL_TX_SENT[1] pulses.
- Ch0..3 all request continuously, pointer 0 -> grant order 0,1,2,3,0. Each new ENG_TX_REQ starts exactly 2 cycles after the previous SENT.
- Ch2 LEN=0 -> ENG_TX_LEN 0. 128 RENs plus SENT -> ERR stays 0 (feature on).
- Ch3 LEN=9 with 3 RENs -> ERR = 1 on the 3rd REN. Separately, SENT after 1 REN -> ERR = 1.
- RST asserted in XFER after 1 of 4 beats -> next cycle all outputs 0, state IDLE. Pending ch0 request is then granted first.
- SENT in same cycle as last REN -> REN and SENT both routed to the owner; IDLE next cycle.

Source files
------------

// File: rtl/tx_write_arbiter_256.sv
// Round-robin arbiter sharing one 256-bit engine TX write path among C_NUM_CHNL channels; grant-to-ENG_TX_REQ is 1 cycle, one write outstanding.
// Backpressure: requests wait until the engine acks and reports sent. Optional beat checking and sticky ERR port: define TX_ARB_BEAT_CHECK_EN.
module tx_write_arbiter_256 #(
   parameter int C_NUM_CHNL   = 4,
   parameter int C_DATA_WIDTH = 256,
   parameter int C_CHNL_W     = (C_NUM_CHNL > 1) ? $clog2(C_NUM_CHNL) : 1
) (
   input  logic                                 CLK,
   input  logic                                 RST,
   input  logic [C_NUM_CHNL-1:0]                CHNL_TX_REQ,
   output logic [C_NUM_CHNL-1:0]                CHNL_TX_REQ_ACK,
   input  logic [64*C_NUM_CHNL-1:0]             CHNL_TX_ADDR,
   input  logic [10*C_NUM_CHNL-1:0]             CHNL_TX_LEN,
   input  logic [C_DATA_WIDTH*C_NUM_CHNL-1:0]   CHNL_TX_DATA,
   output logic [C_NUM_CHNL-1:0]                CHNL_TX_DATA_REN,
   output logic [C_NUM_CHNL-1:0]                CHNL_TX_SENT,
   output logic                                 ENG_TX_REQ,
   input  logic                                 ENG_TX_REQ_ACK,
   output logic [63:0]                          ENG_TX_ADDR,
   output logic [9:0]                           ENG_TX_LEN,
   output logic [C_CHNL_W-1:0]                  ENG_TX_CHNL,
   output logic [C_DATA_WIDTH-1:0]              ENG_TX_DATA,
   input  logic                                 ENG_TX_DATA_REN,
`ifdef TX_ARB_BEAT_CHECK_EN
   input  logic                                 ENG_TX_SENT,
   output logic                                 ERR
`else
   input  logic                                 ENG_TX_SENT
`endif
);

   typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER} state_t;

   state_t                 state_q;
   logic [C_NUM_CHNL-1:0]  grant_q;
   logic [C_CHNL_W-1:0]    idx_q;
   logic [C_CHNL_W-1:0]    ptr_q;
   logic [63:0]            addr_q;
   logic [9:0]             len_q;
   logic                   eng_req_q;

   logic                   win_vld;
   logic [C_CHNL_W-1:0]    win_idx;
   logic [C_NUM_CHNL-1:0]  win_oh;
   logic [63:0]            win_addr;
   logic [9:0]             win_len;
   int                     cand;

   // First requester at or above the pointer, wrapping past the top channel.
   always_comb begin
      win_vld  = 1'b0;
      win_idx  = '0;
      win_oh   = '0;
      win_addr = '0;
      win_len  = '0;
      cand     = 0;
      for (int k = 0; k < C_NUM_CHNL; k++) begin
         cand = int'(ptr_q) + k;
         if (cand >= C_NUM_CHNL) cand = cand - C_NUM_CHNL;
         if (!win_vld && CHNL_TX_REQ[cand]) begin
            win_vld      = 1'b1;
            win_idx      = cand[C_CHNL_W-1:0];
            win_oh       = '0;
            win_oh[cand] = 1'b1;
            win_addr     = CHNL_TX_ADDR[cand*64 +: 64];
            win_len      = CHNL_TX_LEN[cand*10 +: 10];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q   <= S_IDLE;
         grant_q   <= '0;
         idx_q     <= '0;
         ptr_q     <= '0;
         addr_q    <= '0;
         len_q     <= '0;
         eng_req_q <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (win_vld) begin
                  grant_q   <= win_oh;
                  idx_q     <= win_idx;
                  addr_q    <= win_addr;
                  len_q     <= win_len;
                  eng_req_q <= 1'b1;
                  state_q   <= S_REQ;
               end
            end
            S_REQ: begin
               if (ENG_TX_REQ_ACK) begin
                  eng_req_q <= 1'b0;
                  state_q   <= S_XFER;
               end
            end
            S_XFER: begin
               if (ENG_TX_SENT) begin
                  grant_q <= '0;
                  ptr_q   <= (idx_q == C_CHNL_W'(C_NUM_CHNL - 1)) ? '0 : idx_q + C_CHNL_W'(1);
                  state_q <= S_IDLE;
               end
            end
            default: begin
               grant_q   <= '0;
               eng_req_q <= 1'b0;
               state_q   <= S_IDLE;
            end
         endcase
      end
   end

   assign ENG_TX_REQ       = eng_req_q;
   assign ENG_TX_ADDR      = addr_q;
   assign ENG_TX_LEN       = len_q;
   assign ENG_TX_CHNL      = idx_q;
   assign CHNL_TX_REQ_ACK  = (ENG_TX_REQ_ACK && state_q == S_REQ) ? grant_q : '0;
   assign CHNL_TX_SENT     = (ENG_TX_SENT && state_q == S_XFER) ? grant_q : '0;
   assign CHNL_TX_DATA_REN = ENG_TX_DATA_REN ? grant_q : '0;

   // Grant is one-hot or zero, so an OR-of-selected mux yields 0 when idle.
   always_comb begin
      ENG_TX_DATA = '0;
      for (int i = 0; i < C_NUM_CHNL; i++) begin
         if (grant_q[i]) ENG_TX_DATA = CHNL_TX_DATA[i*C_DATA_WIDTH +: C_DATA_WIDTH];
      end
   end

`ifdef TX_ARB_BEAT_CHECK_EN
   logic [7:0]  beats_q;
   logic [7:0]  beats_d;
   logic        err_q;
   logic        ren_hit;
   logic        sent_hit;
   logic [10:0] len_round;

   assign ren_hit   = ENG_TX_DATA_REN && (|grant_q);
   assign sent_hit  = ENG_TX_SENT && (state_q == S_XFER);
   assign beats_d   = (ren_hit && beats_q != 8'd0) ? beats_q - 8'd1 : beats_q;
   assign len_round = {1'b0, win_len} + 11'd7;

   // SENT is judged after the same-cycle REN, so a final beat alongside SENT is legal.
   always_ff @(posedge CLK) begin
      if (RST) begin
         beats_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if (state_q == S_IDLE && win_vld)
            beats_q <= (win_len == 10'd0) ? 8'd128 : len_round[10:3];
         else
            beats_q <= beats_d;
         if ((ren_hit && beats_q == 8'd0) || (sent_hit && beats_d != 8'd0))
            err_q <= 1'b1;
      end
   end

   assign ERR = err_q;
`endif

endmodule
